// File: rtl/nios_system_mult_arbiter_if.sv
// Requester-side bundle for the shared multiplier arbiter: operation request
// channel plus the one-hot result channel.
interface nios_system_mult_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_src1;
    logic [NUM_REQ-1:0][31:0] req_src2;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [31:0]              rsp_result;

    modport master (
        output req_valid, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/nios_system_mult_arbiter.sv
// Round-robin arbiter sharing one 32x32 multiplier cell, one op in flight.
// Define NIOS_SYSTEM_MULT_ARB_STATS_EN to build the completed-operation counter.
module nios_system_mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    nios_system_mult_arbiter_if.slave bus,
    output logic [31:0]               mul_src1,
    output logic [31:0]               mul_src2,
    input  logic [31:0]               mul_result,
    output logic [31:0]               op_count
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] rr_ptr, owner, owner_nxt, gnt_idx;
    logic [2:0]    wait_cnt;
    logic [31:0]   rsp_result;
    logic          gnt_vld;
    logic          rsp_done;

    // Scan from the highest offset down so the nearest requester to rr_ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == idx && bus.req_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IW'(i);
                end
            end
        end
    end

    // req_ready is gated by reset so every output reads zero while reset is held.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = reset_n && (state == IDLE) && gnt_vld && (gnt_idx == IW'(i));
            bus.rsp_valid[i] = (state == RESP) && (owner == IW'(i));
        end
    end

    assign bus.rsp_result = rsp_result;
    assign rsp_done       = (state == RESP) && bus.rsp_ready[owner];
    assign owner_nxt      = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            wait_cnt   <= '0;
            rsp_result <= '0;
            mul_src1   <= '0;
            mul_src2   <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_vld) begin
                    mul_src1 <= bus.req_src1[gnt_idx];
                    mul_src2 <= bus.req_src2[gnt_idx];
                    owner    <= gnt_idx;
                    wait_cnt <= 3'(MUL_LATENCY);
                    state    <= WAIT;
                end
                WAIT: if (wait_cnt == 3'd1) begin
                    rsp_result <= mul_result;
                    wait_cnt   <= '0;
                    state      <= RESP;
                end else begin
                    wait_cnt <= wait_cnt - 3'd1;
                end
                RESP: if (rsp_done) begin
                    rr_ptr <= owner_nxt;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NIOS_SYSTEM_MULT_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      op_count <= '0;
        else if (rsp_done) op_count <= op_count + 32'd1;
    end
`else
    assign op_count = 32'h0;
`endif
endmodule

// File: tb/tb_nios_system_mult_arbiter.sv
// Directed bench: cycle vector table on a latency-1 instance plus hand sequences
// for latency 3, mid-operation reset and the operation counter.
module tb_nios_system_mult_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nios_system_mult_arbiter_if #(.NUM_REQ(N)) ifa ();
    nios_system_mult_arbiter_if #(.NUM_REQ(N)) ifb ();

    logic [31:0] a_src1, a_src2, a_res, a_cnt;
    logic [31:0] b_src1, b_src2, b_res, b_cnt, b_p1, b_p2;

    // Ideal cells: latency 1 is just the operand register, latency 3 adds two stages.
    assign a_res = a_src1 * a_src2;
    always @(posedge clk) begin
        b_p1 <= b_src1 * b_src2;
        b_p2 <= b_p1;
    end
    assign b_res = b_p2;

    nios_system_mult_arbiter #(.NUM_REQ(N), .MUL_LATENCY(1)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(ifa),
        .mul_src1(a_src1), .mul_src2(a_src2), .mul_result(a_res), .op_count(a_cnt)
    );
    nios_system_mult_arbiter #(.NUM_REQ(N), .MUL_LATENCY(3)) u3 (
        .clk(clk), .reset_n(reset_n), .bus(ifb),
        .mul_src1(b_src1), .mul_src2(b_src2), .mul_result(b_res), .op_count(b_cnt)
    );

    typedef struct {
        logic [N-1:0] rv;
        logic [N-1:0] rr;
        logic [N-1:0] ery;
        logic [N-1:0] ev;
        logic [31:0]  er;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] rv, input logic [N-1:0] rr,
                       input logic [N-1:0] ery, input logic [N-1:0] ev, input logic [31:0] er);
        vecs.push_back('{rv: rv, rr: rr, ery: ery, ev: ev, er: er});
    endtask

    // One uncontended op on the latency-1 instance; rsp_ready held high.
    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        p = a * b;
        @(negedge clk);
        ifa.req_valid    = 4'(1 << i);
        ifa.req_src1[i]  = a;
        ifa.req_src2[i]  = b;
        ifa.rsp_ready    = '1;
        #1 chk("op_ready", 32'(ifa.req_ready), 32'(1 << i));
        @(negedge clk);
        ifa.req_valid = '0;
        #1 chk("op_wait", 32'(ifa.rsp_valid), 32'd0);
        @(negedge clk);
        #1 chk("op_valid", 32'(ifa.rsp_valid), 32'(1 << i));
        chk("op_result", ifa.rsp_result, p);
    endtask

    initial begin
        reset_n       = 1'b0;
        ifa.req_valid = 4'b0001;
        ifa.rsp_ready = '0;
        ifb.req_valid = '0;
        ifb.rsp_ready = '0;
        ifa.req_src1  = {32'd6, 32'd7, 32'd4, 32'd3};
        ifa.req_src2  = {32'd7, 32'd9, 32'd5, 32'd5};
        ifb.req_src1  = '0;
        ifb.req_src2  = '0;
        #1;
        chk("rst_req_ready", 32'(ifa.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("rst_rsp_result", ifa.rsp_result, 32'd0);
        chk("rst_mul_src1", a_src1, 32'd0);
        chk("rst_mul_src2", a_src2, 32'd0);
        chk("rst_op_count", a_cnt, 32'd0);
        @(negedge clk);
        reset_n       = 1'b1;
        ifa.req_valid = '0;

        // Contention: 0,1,3,0 at three cycles per op (products 15, 20, 42).
        for (int r = 0; r < 4; r++) begin
            case (r)
                0, 3:    add(4'b1011, 4'b1111, 4'b0001, 4'b0000, 32'd0);
                1:       add(4'b1011, 4'b1111, 4'b0010, 4'b0000, 32'd0);
                default: add(4'b1011, 4'b1111, 4'b1000, 4'b0000, 32'd0);
            endcase
            add(4'b1011, 4'b1111, 4'b0000, 4'b0000, 32'd0);
            case (r)
                0, 3:    add(4'b1011, 4'b1111, 4'b0000, 4'b0001, 32'd15);
                1:       add(4'b1011, 4'b1111, 4'b0000, 4'b0010, 32'd20);
                default: add(4'b1011, 4'b1111, 4'b0000, 4'b1000, 32'd42);
            endcase
        end
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 32'd0);
        // Single requester 0: 3*5.
        add(4'b0001, 4'b1111, 4'b0001, 4'b0000, 32'd0);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 32'd0);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0001, 32'd15);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 32'd0);
        // Backpressure on requester 2 (7*9) with requester 0 waiting.
        add(4'b0100, 4'b1111, 4'b0100, 4'b0000, 32'd0);
        add(4'b0101, 4'b1111, 4'b0000, 4'b0000, 32'd0);
        for (int r = 0; r < 5; r++) add(4'b0101, 4'b1011, 4'b0000, 4'b0100, 32'd63);
        add(4'b0101, 4'b1111, 4'b0000, 4'b0100, 32'd63);
        add(4'b0001, 4'b1111, 4'b0001, 4'b0000, 32'd0);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 32'd0);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0001, 32'd15);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 32'd0);

        foreach (vecs[k]) begin
            @(negedge clk);
            ifa.req_valid = vecs[k].rv;
            ifa.rsp_ready = vecs[k].rr;
            #1;
            chk($sformatf("vec%0d_req_ready", k), 32'(ifa.req_ready), 32'(vecs[k].ery));
            chk($sformatf("vec%0d_rsp_valid", k), 32'(ifa.rsp_valid), 32'(vecs[k].ev));
            if (vecs[k].ev != '0)
                chk($sformatf("vec%0d_rsp_result", k), ifa.rsp_result, vecs[k].er);
        end

        // Latency 3: result appears exactly three edges after acceptance.
        @(negedge clk);
        ifb.rsp_ready   = '1;
        ifb.req_valid   = 4'b0001;
        ifb.req_src1[0] = 32'hFFFF_FFFF;
        ifb.req_src2[0] = 32'd2;
        #1 chk("l3_ready0", 32'(ifb.req_ready), 32'b0001);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            ifb.req_valid = '0;
            #1 chk($sformatf("l3_wait0_e%0d", e), 32'(ifb.rsp_valid), 32'd0);
        end
        chk("l3_mul_src1", b_src1, 32'hFFFF_FFFF);
        @(negedge clk);
        #1 chk("l3_valid0", 32'(ifb.rsp_valid), 32'b0001);
        chk("l3_trunc", ifb.rsp_result, 32'hFFFF_FFFE);
        @(negedge clk);
        ifb.req_valid   = 4'b0010;
        ifb.req_src1[1] = 32'h0001_0000;
        ifb.req_src2[1] = 32'h0001_0000;
        #1 chk("l3_ready1", 32'(ifb.req_ready), 32'b0010);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            ifb.req_valid = '0;
            #1 chk($sformatf("l3_wait1_e%0d", e), 32'(ifb.rsp_valid), 32'd0);
        end
        @(negedge clk);
        #1 chk("l3_valid1", 32'(ifb.rsp_valid), 32'b0010);
        chk("l3_wrap_zero", ifb.rsp_result, 32'd0);

        // Move rr_ptr to 3, then reset in the middle of a WAIT.
        run_op(2, 32'd7, 32'd9);
        @(negedge clk);
        ifa.req_valid = 4'b0100;
        #1 chk("mid_ready", 32'(ifa.req_ready), 32'b0100);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(ifa.req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("mid_rst_rsp_result", ifa.rsp_result, 32'd0);
        chk("mid_rst_mul_src1", a_src1, 32'd0);
        chk("mid_rst_mul_src2", a_src2, 32'd0);
        @(negedge clk);
        reset_n       = 1'b1;
        ifa.req_valid = '0;
        ifa.req_src1[1] = 32'd4;
        ifa.req_src2[1] = 32'd5;
        for (int e = 0; e < 3; e++) begin
            #1 chk($sformatf("post_rst_quiet%0d", e), 32'(ifa.rsp_valid), 32'd0);
            @(negedge clk);
        end
        ifa.req_valid = 4'b1010;
        #1 chk("post_rst_rr_ptr", 32'(ifa.req_ready), 32'b0010);
        @(negedge clk);
        ifa.req_valid = '0;
        @(negedge clk);
        #1 chk("post_rst_valid", 32'(ifa.rsp_valid), 32'b0010);
        chk("post_rst_result", ifa.rsp_result, 32'd20);

        // Nine more ops make ten completions since the reset.
        for (int k = 0; k < 9; k++) run_op(k % N, 32'(k + 2), 32'(3 * k + 1));
        @(negedge clk);
`ifdef NIOS_SYSTEM_MULT_ARB_STATS_EN
        #1 chk("op_count_10", a_cnt, 32'd10);
        force u1.op_count = 32'hFFFF_FFFF;
        #1 release u1.op_count;
        run_op(3, 32'd2, 32'd2);
        @(negedge clk);
        #1 chk("op_count_wrap", a_cnt, 32'd0);
`else
        #1 chk("op_count_off", a_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
